// File: rtl/irq_arbiter_if.sv
// Interrupt arbiter bus: raw sources, mask register access and the CP0 request/ack/eret link.
// Handshake: ir_req stays high from grant until ir_ack is sampled high in REQ; eret then closes the handler.
interface irq_arbiter_if #(parameter int IRQ_NUM = 8);
    logic [IRQ_NUM-1:0] irq_in;
    logic               mask_we;
    logic [IRQ_NUM-1:0] mask_wdata;
    logic [IRQ_NUM-1:0] mask_r;
    logic [IRQ_NUM-1:0] pend_r;
    logic               ir_req;
    logic               ir_ack;
    logic               eret;
    logic [2:0]         cause;
    logic               busy;
    logic [1:0]         dbg_state;

    modport master (
        output irq_in, mask_we, mask_wdata, ir_ack, eret,
        input  mask_r, pend_r, ir_req, cause, busy, dbg_state
    );

    modport slave (
        input  irq_in, mask_we, mask_wdata, ir_ack, eret,
        output mask_r, pend_r, ir_req, cause, busy, dbg_state
    );
endinterface

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: synchronizes and edge-detects sources, pends them and hands one at a time to CP0.
// Define IRQ_ROUND_ROBIN_EN for rotating priority; the default build is fixed lowest-index priority.
module irq_arbiter #(
    parameter int IRQ_NUM = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    irq_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IRQ_NUM-1:0] sync1_q, sync2_q, prev_q;
    logic [IRQ_NUM-1:0] mask_q, pend_q, pend_d;
    logic [IRQ_NUM-1:0] rise, eligible, clr, search;
    logic               ir_req_q, ir_req_d;
    logic [2:0]         cause_q, cause_d;
    logic [2:0]         lo_idx, win_idx;
    logic               win_vld;
    logic               take_ack;

    assign rise     = sync2_q & ~prev_q;
    assign eligible = pend_q & mask_q;
    assign take_ack = (state_q == REQ) && bus.ir_ack;
    assign win_vld  = |eligible;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [2:0]           ptr_q;
    logic [2*IRQ_NUM-1:0] dbl;
    logic [3:0]           rr_sum;

    // Rotate so bit 0 of the search vector is the source at the pointer.
    assign dbl     = {eligible, eligible} >> ptr_q;
    assign search  = dbl[IRQ_NUM-1:0];
    assign rr_sum  = {1'b0, ptr_q} + {1'b0, lo_idx};
    assign win_idx = (rr_sum >= 4'(IRQ_NUM)) ? 3'(rr_sum - 4'(IRQ_NUM)) : rr_sum[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (take_ack) begin
            ptr_q <= (cause_q == 3'(IRQ_NUM - 1)) ? 3'd0 : cause_q + 3'd1;
        end
    end
`else
    assign search  = eligible;
    assign win_idx = lo_idx;
`endif

    always_comb begin
        lo_idx = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (search[i]) lo_idx = 3'(i);
        end
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            clr[i] = take_ack && (cause_q == 3'(i));
        end
    end

    // A new edge on the bit being acknowledged must survive the clear.
    assign pend_d = (pend_q & ~clr) | rise;

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        ir_req_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = REQ;
                    cause_d = win_idx;
                end
            end
            REQ: begin
                if (bus.ir_ack) state_d = SERVICE;
                else            ir_req_d = 1'b1;
            end
            SERVICE: begin
                if (bus.eret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            mask_q   <= '1;
            pend_q   <= '0;
            ir_req_q <= 1'b0;
            cause_q  <= '0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= bus.irq_in;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            pend_q   <= pend_d;
            ir_req_q <= ir_req_d;
            cause_q  <= cause_d;
            if (bus.mask_we) mask_q <= bus.mask_wdata;
        end
    end

    assign bus.mask_r    = mask_q;
    assign bus.pend_r    = pend_q;
    assign bus.ir_req    = ir_req_q;
    assign bus.cause     = cause_q;
    assign bus.busy      = (state_q == SERVICE);
    assign bus.dbg_state = state_q;
endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 The block SHALL have parameter IRQ_NUM, default 8, number of external interrupt sources, legal range 2..8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single main clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port irq_in, input, IRQ_NUM bits: raw asynchronous interrupt sources, one per bit.
REQ-005 The block SHALL have ports mask_we (input, 1 bit) and mask_wdata (input, IRQ_NUM bits): the enable-mask write strobe and data.
REQ-006 The block SHALL have ports mask_r and pend_r, outputs, IRQ_NUM bits each: the current mask register and pending register.
REQ-007 The block SHALL have port ir_req, output, 1 bit: interrupt request to the CP0 ir_in input.
REQ-008 The block SHALL have port ir_ack, input, 1 bit: CP0 has taken the interrupt (jump_en for an interrupt).
REQ-009 The block SHALL have port eret, input, 1 bit: a one-cycle ERET indication from CP0 operation decode.
REQ-010 The block SHALL have port cause, output, 3 bits: index of the granted source.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a handler is in service.

Function
REQ-012 Each irq_in bit SHALL pass through a 2-flop synchronizer followed by a rising-edge detector, registered against the previous synchronized value.
REQ-013 A detected rising edge SHALL set the matching pend bit, so that the pend bit is visible 3 clk edges after irq_in rises.
REQ-014 A mask bit equal to 1 SHALL enable its source; a masked source SHALL still set pend but SHALL NOT be granted.
REQ-015 When mask_we=1, mask_wdata SHALL be loaded into mask_r on the next edge.
REQ-016 The FSM SHALL have states IDLE, REQ and SERVICE, and SHALL be in IDLE after reset.
REQ-017 In IDLE, if (pend & mask) is nonzero, the block SHALL latch the winning index into cause and move to REQ; ir_req SHALL be high from the next cycle.
REQ-018 In REQ, ir_req SHALL be held high until ir_ack=1, and SHALL NOT be withdrawn when mask or pend changes.
REQ-019 On ir_ack in REQ, the block SHALL clear pend[cause], drop ir_req on the next cycle and move to SERVICE; busy SHALL be 1 in SERVICE.
REQ-020 In SERVICE, new edges SHALL accumulate in pend only; on eret the block SHALL move to IDLE, and arbitration SHALL resume the following cycle.
REQ-021 eret in IDLE or REQ, and ir_ack in IDLE or SERVICE, SHALL be ignored.
REQ-022 When a set and a clear hit the same pend bit in the same cycle, the set SHALL win.
REQ-023 In fixed-priority mode, the lowest-index eligible source SHALL win.
REQ-024 cause SHALL hold its value from grant until the next grant; bits above IRQ_NUM-1 SHALL be ignored.

Reset
REQ-025 While rst_n=0, the block SHALL force: state IDLE; sync flops, edge flops, pend_r, ir_req, busy and cause all 0; mask_r all 1; round-robin pointer 0.
REQ-026 Reset asserted mid-REQ or mid-SERVICE SHALL drop ir_req and busy immediately, without waiting for clk.

Configuration
REQ-027 When IRQ_ROUND_ROBIN_EN is defined, the search SHALL start at a pointer, and the pointer SHALL load (cause+1) mod IRQ_NUM on each ir_ack, wrapping from IRQ_NUM-1 to 0.
REQ-028 When IRQ_ROUND_ROBIN_EN is not defined, the block SHALL use fixed priority per REQ-023 and SHALL contain no pointer register.

Verification
REQ-029 Bench case: reset, then pulse irq_in[2] -> pend_r=0x04 at edge 3, ir_req=1 at edge 5, cause=2; ir_ack -> pend_r=0x00, busy=1; eret -> busy=0.
REQ-030 Bench case: irq_in[5] and irq_in[1] rise together, fixed priority -> cause=1 first; after eret, cause=5.
REQ-031 Bench case: mask_wdata=0xFB, then edge on irq_in[2] -> pend_r=0x04 and ir_req stays 0; mask back to 0xFF -> ir_req=1 with cause=2.
REQ-032 Bench case: in SERVICE, edge on irq_in[3] -> ir_req stays 0 until eret, then ir_req=1 with cause=3.
REQ-033 Bench case: IRQ_ROUND_ROBIN_EN defined, irq_in[0] and irq_in[1] pulsed repeatedly -> grants alternate 0,1,0,1; with pointer=7, pend=0x81 -> cause=7, then 0.
REQ-034 Bench case: rst_n low while in REQ -> ir_req=0 asynchronously, pend_r=0, mask_r=0xFF.
